// File: rtl/riscv_mem_arb.sv
// riscv_mem_arb: shares one single-outstanding memory bus between the
// instruction-fetch port and the load/store port. Builds byte enables and
// lane-shifted store data, and rejects misaligned data accesses locally.
module riscv_mem_arb #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  // instruction fetch port
  input  logic              imem_req_i,
  input  logic [XLEN-1:0]   imem_adr_i,
  output logic              imem_ack_o,
  output logic              imem_err_o,
  output logic [XLEN-1:0]   imem_q_o,
  // load/store port
  input  logic              dmem_req_i,
  input  logic              dmem_we_i,
  input  logic [2:0]        dmem_size_i,
  input  logic [XLEN-1:0]   dmem_adr_i,
  input  logic [XLEN-1:0]   dmem_d_i,
  output logic              dmem_ack_o,
  output logic              dmem_err_o,
  output logic              dmem_misaligned_o,
  output logic [XLEN-1:0]   dmem_q_o,
  // external bus
  output logic              bus_req_o,
  output logic              bus_we_o,
  output logic [XLEN-1:0]   bus_adr_o,
  output logic [XLEN/8-1:0] bus_be_o,
  output logic [XLEN-1:0]   bus_d_o,
  input  logic              bus_ack_i,
  input  logic              bus_err_i,
  input  logic [XLEN-1:0]   bus_q_i
);

  localparam int unsigned BW   = XLEN / 8;
  localparam int unsigned OFFW = (XLEN == 64) ? 3 : 2;
  localparam int unsigned CNTW = 4;
  localparam logic [CNTW-1:0] STARVE_LIM = CNTW'(STARVE_MAX);

  typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D, FAULT} state_e;

  state_e          state_q;
  logic [CNTW-1:0] starve_q;
  logic [OFFW-1:0] off_c;
  logic            misaligned_c;
  logic [BW-1:0]   be_c;
  logic [XLEN-1:0] wdata_c;
  logic            grant_d_c;
  logic            grant_i_c;
  logic            done_c;
  logic            unused_size_msb;

  // Size bit 2 (unsigned-load flag) has no meaning on the bus side.
  assign unused_size_msb = dmem_size_i[2];

  // Data access decode: byte lane offset, enables, alignment, shifted store data.
  always_comb begin
    off_c        = dmem_adr_i[OFFW-1:0];
    be_c         = '0;
    misaligned_c = 1'b0;
    case (dmem_size_i[1:0])
      2'd0: be_c = BW'(1) << off_c;
      2'd1: begin
        be_c         = BW'(3) << off_c;
        misaligned_c = dmem_adr_i[0];
      end
      2'd2: begin
        be_c         = BW'(15) << off_c;
        misaligned_c = |dmem_adr_i[1:0];
      end
      default: begin
        be_c         = '1;
        misaligned_c = (XLEN == 64) ? (|dmem_adr_i[2:0]) : 1'b1;
      end
    endcase
    wdata_c = dmem_d_i << {off_c, 3'b000};
  end

  // Grant selection: data wins unless fetch has waited STARVE_MAX data grants.
  always_comb begin
    grant_d_c = dmem_req_i && (!imem_req_i || (starve_q != STARVE_LIM));
    grant_i_c = imem_req_i && !grant_d_c;
    done_c    = bus_ack_i || bus_err_i;
  end

  // Responses follow the bus in the completion cycle; a dropped req discards them.
  assign imem_ack_o = (state_q == BUSY_I) && imem_req_i && bus_ack_i && !bus_err_i;
  assign imem_err_o = (state_q == BUSY_I) && imem_req_i && bus_err_i;
  assign dmem_ack_o = (state_q == BUSY_D) && dmem_req_i && bus_ack_i && !bus_err_i;
  assign dmem_err_o = (state_q == BUSY_D) && dmem_req_i && bus_err_i;
  assign imem_q_o   = bus_q_i;
  assign dmem_q_o   = bus_q_i;

  // Arbiter FSM with registered bus outputs and starvation counter.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      starve_q          <= '0;
      bus_req_o         <= 1'b0;
      bus_we_o          <= 1'b0;
      bus_adr_o         <= '0;
      bus_be_o          <= '0;
      bus_d_o           <= '0;
      dmem_misaligned_o <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_d_c) begin
            if (imem_req_i) begin
              starve_q <= (starve_q == STARVE_LIM) ? starve_q : starve_q + CNTW'(1);
            end else begin
              starve_q <= '0;
            end
            if (misaligned_c) begin
              state_q           <= FAULT;
              dmem_misaligned_o <= 1'b1;
            end else begin
              state_q   <= BUSY_D;
              bus_req_o <= 1'b1;
              bus_we_o  <= dmem_we_i;
              bus_adr_o <= dmem_adr_i;
              bus_be_o  <= be_c;
              bus_d_o   <= wdata_c;
            end
          end else if (grant_i_c) begin
            starve_q  <= '0;
            state_q   <= BUSY_I;
            bus_req_o <= 1'b1;
            bus_we_o  <= 1'b0;
            bus_adr_o <= imem_adr_i;
            bus_be_o  <= '1;
            bus_d_o   <= '0;
          end
        end
        BUSY_I, BUSY_D: begin
          if (done_c) begin
            state_q   <= IDLE;
            bus_req_o <= 1'b0;
            bus_we_o  <= 1'b0;
            bus_adr_o <= '0;
            bus_be_o  <= '0;
            bus_d_o   <= '0;
          end
        end
        FAULT: begin
          state_q           <= IDLE;
          dmem_misaligned_o <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/riscv_mem_arb.md
Name: riscv_mem_arb

Overview:
- Shares a single-outstanding memory bus between the instruction-fetch port (imem) and the load/store port (dmem).
- Generates bus byte-enables and lane-aligned store data.
- Detects misaligned data accesses without touching the bus.
- Returns ack, err and misaligned responses to the requester that was granted.
- Sits between the fetch and memory/write-back pipeline stages and the external bus interface. The dmem response timing matches the write-back stall logic, which releases on ack, err or misaligned.

Parameters:
- XLEN, 32: data/address width; 32 or 64 only.
- STARVE_MAX, 4: consecutive data grants allowed while imem waits; range 1..15.

Ports:
- clk_i  in  1  clock; all logic rising-edge.
- rst_i  in  1  reset; synchronous, active-high.
- imem_req_i  in  1  fetch request; held until imem_ack_o or imem_err_o.
- imem_adr_i  in  XLEN  fetch address.
- imem_ack_o  out  1  fetch complete; imem_q_o valid.
- imem_err_o  out  1  fetch bus error.
- imem_q_o  out  XLEN  fetch data.
- dmem_req_i  in  1  data request; held until ack, err or misaligned.
- dmem_we_i  in  1  1 = store.
- dmem_size_i  in  3  [1:0]: 0 byte, 1 half, 2 word, 3 dword; bit 2 ignored.
- dmem_adr_i  in  XLEN  data address.
- dmem_d_i  in  XLEN  store data, right-justified.
- dmem_ack_o  out  1  data complete.
- dmem_err_o  out  1  data bus error.
- dmem_misaligned_o  out  1  access not performed: misaligned or illegal size.
- dmem_q_o  out  XLEN  raw bus word; the consumer extracts the lane.
- bus_req_o  out  1  bus request.
- bus_we_o  out  1  bus write.
- bus_adr_o  out  XLEN  bus address (unmodified requester address).
- bus_be_o  out  XLEN/8  byte enables.
- bus_d_o  out  XLEN  lane-shifted write data.
- bus_ack_i  in  1  bus transfer done.
- bus_err_i  in  1  bus error; if asserted together with ack, err wins.
- bus_q_i  in  XLEN  bus read data.

Behaviour:
- Reset values:
  - State IDLE, starvation counter 0.
  - bus_req_o, bus_we_o, dmem_misaligned_o = 0.
  - bus_adr_o, bus_be_o, bus_d_o = 0.
  - All ack/err outputs = 0.
  - Reset mid-transaction abandons it; no response is issued.
- FSM states: IDLE, BUSY_I, BUSY_D, FAULT.
- IDLE, grant decision (registered):
  - Only dmem requesting: dmem is selected.
  - Only imem requesting: imem is selected.
  - Both requesting: dmem wins, unless the starvation counter equals STARVE_MAX, in which case imem wins.
  - A selected dmem request that is misaligned goes to FAULT.
  - Otherwise, the selected requester goes to BUSY_I or BUSY_D, and its address and enables are registered onto the bus.
- Bus timing: bus_req_o rises the cycle after the request is sampled in IDLE. Bus outputs stay stable until ack or err.
- BUSY_x:
  - On bus_ack_i or bus_err_i, the matching response output is driven combinationally in that same cycle.
  - The response is gated by the requester's req still being high. A dropped req means the response is discarded, but the bus cycle still completes.
  - Next cycle: bus_req_o = 0 and state = IDLE. Minimum issue spacing is 2 cycles; one idle bus cycle always separates transactions.
- q outputs: imem_q_o and dmem_q_o = bus_q_i at all times (qualified only by ack).
- FAULT:
  - dmem_misaligned_o = 1 for exactly one cycle (registered), then return to IDLE.
  - No bus activity; no grant is evaluated in FAULT.
- Misalignment rules:
  - Half: adr[0] != 0.
  - Word: adr[1:0] != 0.
  - Dword: adr[2:0] != 0 when XLEN=64; dword is always misaligned when XLEN=32.
  - Byte: never misaligned.
- bus_be_o:
  - Byte: 1 << off.
  - Half: 3 << off.
  - Word: 4'hF << off.
  - Dword: all ones.
  - off = adr[1:0] for XLEN=32, adr[2:0] for XLEN=64.
  - Fetch: all ones.
- Data lanes:
  - bus_d_o = dmem_d_i << (8*off).
  - bus_we_o = dmem_we_i for data; 0 for fetch.
- Starvation counter:
  - Increments (saturating at STARVE_MAX) on a dmem grant while imem_req_i = 1.
  - Clears on any imem grant, and on a dmem grant while imem_req_i = 0.
  - A FAULT grant counts as a dmem grant.

Test Plan:
- Single fetch, XLEN=32:
  - Stimulus: imem req adr=0x200 at cycle 0; bus_ack_i with q=0x00000013 at cycle 3.
  - Response: bus_req_o=1 in cycles 1-3 with be=0xF, we=0; imem_ack_o=1 and imem_q_o=0x13 at cycle 3; bus_req_o=0 at cycle 4.
- Store byte:
  - Stimulus: adr=0x1003, d=0xA5, size=0.
  - Response: bus_be_o=0x8, bus_d_o=0xA5000000, bus_we_o=1; dmem_ack_o in the bus-ack cycle.
- Misaligned word load:
  - Stimulus: adr=0x1002, size=2.
  - Response: dmem_misaligned_o=1 for exactly one cycle at cycle 1; bus_req_o never asserts; dmem_ack_o stays 0.
- Contention, STARVE_MAX=4:
  - Stimulus: imem and dmem both requesting continuously, every transaction acked 1 cycle after request.
  - Response: grant order D,D,D,D,I,D,D,D,D,I.
- Bus error on load:
  - Stimulus: bus_err_i and bus_ack_i both asserted in the same cycle.
  - Response: dmem_err_o=1, dmem_ack_o=0; FSM returns to IDLE next cycle.
- Reset mid-BUSY_D:
  - Stimulus: rst_i=1 for one cycle while BUSY_D; bus_ack_i arrives after reset.
  - Response: all outputs 0 next cycle, state IDLE; the later bus_ack_i produces no dmem_ack_o.
